if_fetch_stage: RTL

Instruction Fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID latch, which in turn feeds the ID/EX latch.
- Owns the PC and drives the instruction-memory request (iREN/imemaddr).
- Presents instr/pcp4/valid to the IF/ID latch.
- Absorbs one fetched word in a skid buffer when the pipe stalls.
- Handles jump/branch redirects, including a redirect that lands while an icache request is in flight.

---
 rtl/if_fetch_stage_if.sv | 26 ++
 rtl/if_fetch_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: icache request/response, hazard/redirect controls and the IF/ID-facing outputs.
// master = fetch stage, slave = the surrounding pipeline / icache.
interface if_fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] instr_out;
  logic [31:0] pcp4_out;
  logic        valid_out;
  logic [31:0] pc_out;

  modport master (
    input  ihit, imemload, stall, redirect, redirect_pc, halt,
    output iREN, imemaddr, instr_out, pcp4_out, valid_out, pc_out
  );

  modport slave (
    output ihit, imemload, stall, redirect, redirect_pc, halt,
    input  iREN, imemaddr, instr_out, pcp4_out, valid_out, pc_out
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction fetch stage: PC ownership, one-entry skid buffer, redirect with stale-request drop.
// Optional IF_FETCH_PERF_EN adds saturating fetch_cnt / stall_cnt outputs.
module if_fetch_stage #(
  parameter logic [31:0] PC_INIT         = 32'h0000_0000,
  parameter bit          SKID_EN_DEFAULT = 1'b1
) (
  input  logic            CLK,
  input  logic            nRST,
  if_fetch_stage_if.master fif
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pcp4;
  logic        buf_valid;

  logic [31:0] pc_plus4;
  logic [31:0] target_pc;
  logic        hit_ok;
  logic        ren;
  logic        valid;
  logic        transfer;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] pcp4;

  assign pc_plus4  = pc + 32'd4;
  assign target_pc = fif.redirect_pc & 32'hFFFF_FFFC;

  // Without the skid buffer a stall closes the request, so a hit is only usable when not stalled.
  assign hit_ok = fif.ihit & (SKID_EN_DEFAULT | ~fif.stall);

  always_comb begin
    ren   = 1'b0;
    valid = 1'b0;
    addr  = pc;
    instr = 32'h0;
    pcp4  = pc_plus4;
    case (state)
      RUN: begin
        ren   = ~buf_valid & (SKID_EN_DEFAULT | ~fif.stall);
        valid = (buf_valid | hit_ok) & ~fif.redirect;
        if (buf_valid) begin
          instr = buf_instr;
          pcp4  = buf_pcp4;
        end else begin
          instr = fif.imemload;
          pcp4  = pc_plus4;
        end
      end
      DROP: begin
        ren  = 1'b1;
        addr = drop_addr;
      end
      default: begin
      end
    endcase
  end

  assign transfer      = valid & ~fif.stall;
  assign fif.iREN      = ren;
  assign fif.imemaddr  = addr;
  assign fif.instr_out = instr;
  assign fif.pcp4_out  = pcp4;
  assign fif.valid_out = valid;
  assign fif.pc_out    = pc;

  // Halt beats redirect, redirect beats stall; a redirect with an unanswered request must wait it out in DROP.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= BOOT;
      pc        <= PC_INIT;
      buf_valid <= 1'b0;
      buf_instr <= 32'h0;
      buf_pcp4  <= 32'h0;
      drop_addr <= 32'h0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (fif.halt) begin
            state <= HALTED;
          end else if (fif.redirect) begin
            pc        <= target_pc;
            buf_valid <= 1'b0;
            if (ren & ~fif.ihit) begin
              drop_addr <= pc;
              state     <= DROP;
            end
          end else if (buf_valid) begin
            if (!fif.stall) buf_valid <= 1'b0;
          end else if (hit_ok) begin
            pc <= pc_plus4;
            if (fif.stall) begin
              buf_valid <= 1'b1;
              buf_instr <= fif.imemload;
              buf_pcp4  <= pc_plus4;
            end
          end
        end
        DROP: begin
          if (fif.halt) begin
            state <= HALTED;
          end else begin
            if (fif.redirect) pc <= target_pc;
            if (fif.ihit) state <= RUN;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Counters only move in RUN, so they freeze once HALTED is reached.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (transfer && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
      if (state == RUN && fif.stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
